// File: rtl/multicycle_pkg.sv
// Shared definitions for the multi-cycle RV32I control unit.
// Holds the state encoding, opcode constants, ALU operation codes and the
// datapath select codes, plus small helpers used by the control FSM.
package multicycle_pkg;

    // FSM state encoding (also exported on the debug state port)
    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECUTER = 4'd6;
    localparam logic [3:0] S_ALUWB    = 4'd7;
    localparam logic [3:0] S_EXECUTEI = 4'd8;
    localparam logic [3:0] S_JAL      = 4'd9;
    localparam logic [3:0] S_BRANCH   = 4'd10;
    localparam logic [3:0] S_JALR     = 4'd11;
    localparam logic [3:0] S_LUI      = 4'd12;
    localparam logic [3:0] S_FAULT    = 4'd13;

    // Opcodes
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    // ALU operations
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // FSM-to-ALU-decoder operation class
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Immediate formats
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    // Result selects
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;
    localparam logic [1:0] RES_PC4    = 2'b11;

    // ALU operand selects
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;
    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    // States that wait on the shared memory port and are watched by the timeout
    function automatic logic is_mem_state(input logic [3:0] s);
        return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
    endfunction

    // Immediate format implied by the opcode (formats without an immediate give I)
    function automatic logic [2:0] imm_for_opcode(input logic [6:0] op);
        case (op)
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            OP_LUI:    return IMM_U;
            default:   return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// ALU decoder for the multi-cycle control unit (purely combinational).
// Ports:
//   alu_op      - operation class from the FSM (add / sub / funct-decoded)
//   funct3      - instruction funct3
//   funct7_5    - instruction bit 30, selects sub for R-type add/sub
//   is_rtype    - high in the register-register execute state
//   alu_control - ALU operation code
module mc_alu_decoder
    import multicycle_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       is_rtype,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // bit 30 is part of the immediate for I-type, so it only
                    // means sub for register-register instructions
                    3'b000:  alu_control = (is_rtype && funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Control FSM for the multi-cycle RV32I core.
// Sequences fetch/decode/execute/memory/writeback over one shared memory
// port, resolves branches, pulses instr_retired once per instruction,
// watches memory waits with a timeout and parks in a sticky FAULT state.
// Ports:
//   clk, reset (async, active-high)
//   opcode/funct3/funct7_5 - instruction register fields
//   zero/lt/ltu            - ALU comparison flags for branches
//   mem_ready              - memory completes the access this cycle
//   mem_req/mem_write/adr_src, ir_write/pc_write/reg_write - datapath strobes
//   alu_src_a/alu_src_b/imm_src/result_src/alu_control     - datapath selects
//   state (debug), instr_retired, fault
module multicycle_control_unit
    import multicycle_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 8,
    parameter bit ENABLE_EXT  = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       zero,
    input  logic       lt,
    input  logic       ltu,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] imm_src,
    output logic [1:0] result_src,
    output logic [2:0] alu_control,
    output logic [3:0] state,
    output logic       instr_retired,
    output logic       fault
);

    localparam bit               WD_EN        = (MEM_TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

    logic [3:0]       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [3:0]       decode_target;
    logic             taken;
    logic             timeout;
    logic [1:0]       alu_op;

    logic mem_req_int, mem_write_int, ir_write_int, pc_write_int;
    logic reg_write_int, retired_int;

    // ---------------- state and wait counter ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= S_FETCH;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign timeout = WD_EN && is_mem_state(state_reg) && !mem_ready
                     && (cnt_reg == TIMEOUT_LAST);

    // Counter restarts on every state change (covers entry) and on any
    // completed access; it only runs while a memory state is stalled.
    always_comb begin
        cnt_next = '0;
        if (state_next == state_reg && is_mem_state(state_reg) && !mem_ready)
            cnt_next = cnt_reg + CNT_W'(1);
    end

    // ---------------- decode and branch resolution ----------------
    always_comb begin
        decode_target = S_FAULT;
        case (opcode)
            OP_LOAD, OP_STORE: decode_target = S_MEMADR;
            OP_RTYPE:          decode_target = S_EXECUTER;
            OP_IALU:           decode_target = S_EXECUTEI;
            OP_JAL:            decode_target = S_JAL;
            // the reduced decoder only knows BEQ
            OP_BRANCH:         decode_target = (ENABLE_EXT || funct3 == 3'b000) ? S_BRANCH : S_FAULT;
            OP_JALR:           decode_target = ENABLE_EXT ? S_JALR : S_FAULT;
            OP_LUI:            decode_target = ENABLE_EXT ? S_LUI : S_FAULT;
            default:           decode_target = S_FAULT;
        endcase
    end

    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000:  taken = zero;
            3'b001:  taken = !zero;
            3'b100:  taken = lt;
            3'b101:  taken = !lt;
            3'b110:  taken = ltu;
            3'b111:  taken = !ltu;
            default: taken = 1'b0;
        endcase
    end

    // ---------------- next state ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_FETCH: begin
                if (mem_ready)    state_next = S_DECODE;
                else if (timeout) state_next = S_FAULT;
            end
            S_DECODE:   state_next = decode_target;
            S_MEMADR:   state_next = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD: begin
                if (mem_ready)    state_next = S_MEMWB;
                else if (timeout) state_next = S_FAULT;
            end
            S_MEMWB:    state_next = S_FETCH;
            S_MEMWRITE: begin
                if (mem_ready)    state_next = S_FETCH;
                else if (timeout) state_next = S_FAULT;
            end
            S_EXECUTER, S_EXECUTEI, S_JAL, S_LUI: state_next = S_ALUWB;
            S_ALUWB, S_JALR, S_BRANCH:            state_next = S_FETCH;
            S_FAULT:    state_next = S_FAULT;
            default:    state_next = S_FAULT;
        endcase
    end

    // ---------------- outputs ----------------
    always_comb begin
        mem_req_int   = 1'b0;
        mem_write_int = 1'b0;
        adr_src       = 1'b0;
        ir_write_int  = 1'b0;
        pc_write_int  = 1'b0;
        reg_write_int = 1'b0;
        retired_int   = 1'b0;
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_RS2;
        imm_src       = IMM_I;
        result_src    = RES_ALUOUT;
        alu_op        = ALUOP_ADD;
        case (state_reg)
            S_FETCH: begin
                mem_req_int  = 1'b1;
                alu_src_a    = SRCA_PC;
                alu_src_b    = SRCB_FOUR;
                result_src   = RES_ALU;
                ir_write_int = mem_ready;
                pc_write_int = mem_ready;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                imm_src   = imm_for_opcode(opcode);
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                mem_req_int = 1'b1;
                adr_src     = 1'b1;
            end
            S_MEMWB: begin
                result_src    = RES_MEM;
                reg_write_int = 1'b1;
                retired_int   = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req_int   = 1'b1;
                mem_write_int = 1'b1;
                adr_src       = 1'b1;
                retired_int   = mem_ready;
            end
            S_EXECUTER: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                alu_op    = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                result_src    = RES_ALUOUT;
                reg_write_int = 1'b1;
                retired_int   = 1'b1;
            end
            S_JAL: begin
                alu_src_a    = SRCA_OLDPC;
                alu_src_b    = SRCB_FOUR;
                result_src   = RES_ALUOUT;
                pc_write_int = 1'b1;
            end
            S_JALR: begin
                alu_src_a     = SRCA_RS1;
                alu_src_b     = SRCB_IMM;
                result_src    = RES_PC4;
                reg_write_int = 1'b1;
                pc_write_int  = 1'b1;
                retired_int   = 1'b1;
            end
            S_LUI: begin
                imm_src   = IMM_U;
                alu_src_a = SRCA_ZERO;
                alu_src_b = SRCB_IMM;
            end
            S_BRANCH: begin
                alu_src_a    = SRCA_RS1;
                alu_src_b    = SRCB_RS2;
                alu_op       = ALUOP_SUB;
                result_src   = RES_ALUOUT;
                pc_write_int = taken;
                retired_int  = 1'b1;
            end
            default: ;
        endcase
    end

    // Strobes are forced low while reset is held so nothing fires before
    // the first real fetch.
    assign mem_req       = mem_req_int   & ~reset;
    assign mem_write     = mem_write_int & ~reset;
    assign ir_write      = ir_write_int  & ~reset;
    assign pc_write      = pc_write_int  & ~reset;
    assign reg_write     = reg_write_int & ~reset;
    assign instr_retired = retired_int   & ~reset;
    assign fault         = (state_reg == S_FAULT);
    assign state         = state_reg;

    mc_alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .funct7_5    (funct7_5),
        .is_rtype    (state_reg == S_EXECUTER),
        .alu_control (alu_control)
    );

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit. Two instances share the
// inputs: dut_a with default parameters, dut_b with MEM_TIMEOUT=4 and the
// reduced decoder. Each stimulus cycle pushes a hand-written expected output
// vector; a negedge monitor pops and compares against the selected instance.
module tb_multicycle_control_unit;

    typedef struct packed {
        logic [3:0] st;
        logic [7:0] stb;   // mem_req,mem_write,adr_src,ir_write,pc_write,reg_write,retired,fault
        logic [1:0] a;
        logic [1:0] b;
        logic [2:0] imm;
        logic [1:0] rs;
        logic [2:0] alu;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] opcode = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       funct7_5 = 1'b0;
    logic       zero = 1'b0, lt = 1'b0, ltu = 1'b0;
    logic       mem_ready = 1'b0;

    logic       a_mem_req, a_mem_write, a_adr_src, a_ir_write, a_pc_write, a_reg_write;
    logic [1:0] a_src_a, a_src_b, a_result_src;
    logic [2:0] a_imm_src, a_alu_control;
    logic [3:0] a_state;
    logic       a_retired, a_fault;

    logic       b_mem_req, b_mem_write, b_adr_src, b_ir_write, b_pc_write, b_reg_write;
    logic [1:0] b_src_a, b_src_b, b_result_src;
    logic [2:0] b_imm_src, b_alu_control;
    logic [3:0] b_state;
    logic       b_retired, b_fault;

    always #5 clk = ~clk;

    multicycle_control_unit dut_a (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
        .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
        .mem_req(a_mem_req), .mem_write(a_mem_write), .adr_src(a_adr_src),
        .ir_write(a_ir_write), .pc_write(a_pc_write), .reg_write(a_reg_write),
        .alu_src_a(a_src_a), .alu_src_b(a_src_b), .imm_src(a_imm_src),
        .result_src(a_result_src), .alu_control(a_alu_control), .state(a_state),
        .instr_retired(a_retired), .fault(a_fault)
    );

    multicycle_control_unit #(.MEM_TIMEOUT(4), .CNT_W(8), .ENABLE_EXT(1'b0)) dut_b (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
        .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
        .mem_req(b_mem_req), .mem_write(b_mem_write), .adr_src(b_adr_src),
        .ir_write(b_ir_write), .pc_write(b_pc_write), .reg_write(b_reg_write),
        .alu_src_a(b_src_a), .alu_src_b(b_src_b), .imm_src(b_imm_src),
        .result_src(b_result_src), .alu_control(b_alu_control), .state(b_state),
        .instr_retired(b_retired), .fault(b_fault)
    );

    vec_t act_a, act_b;
    assign act_a = {a_state, {a_mem_req, a_mem_write, a_adr_src, a_ir_write, a_pc_write,
                    a_reg_write, a_retired, a_fault}, a_src_a, a_src_b, a_imm_src,
                    a_result_src, a_alu_control};
    assign act_b = {b_state, {b_mem_req, b_mem_write, b_adr_src, b_ir_write, b_pc_write,
                    b_reg_write, b_retired, b_fault}, b_src_a, b_src_b, b_imm_src,
                    b_result_src, b_alu_control};

    // scoreboard queues
    vec_t  exp_q[$];
    bit    sel_q[$];
    string nm_q[$];
    int    total = 0;
    int    bad = 0;

    function automatic vec_t mk(input logic [3:0] st, input logic [7:0] stb,
                                input logic [1:0] a, input logic [1:0] b,
                                input logic [2:0] imm, input logic [1:0] rs,
                                input logic [2:0] alu);
        vec_t v;
        v.st = st; v.stb = stb; v.a = a; v.b = b; v.imm = imm; v.rs = rs; v.alu = alu;
        return v;
    endfunction

    // hand-written vectors reused across instructions
    vec_t V_RST, V_FETCH_RDY, V_FETCH_STALL, V_ALUWB, V_FAULT;

    task automatic cyc(input bit sel, input logic rst, input logic mr,
                       input vec_t v, input string nm);
        reset     = rst;
        mem_ready = mr;
        exp_q.push_back(v);
        sel_q.push_back(sel);
        nm_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        opcode = op; funct3 = f3; funct7_5 = f7;
    endtask

    // monitor: compare whenever an expectation is pending
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            vec_t  e, got;
            bit    s;
            string n;
            e = exp_q.pop_front();
            s = sel_q.pop_front();
            n = nm_q.pop_front();
            got = s ? act_b : act_a;
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL %s: got st=%0d stb=%b a=%b b=%b imm=%b rs=%b alu=%b, want st=%0d stb=%b a=%b b=%b imm=%b rs=%b alu=%b",
                         n, got.st, got.stb, got.a, got.b, got.imm, got.rs, got.alu,
                         e.st, e.stb, e.a, e.b, e.imm, e.rs, e.alu);
            end else begin
                $display("check %s: st=%0d stb=%b ok", n, got.st, got.stb);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running want done");
        $fatal(1, "time limit");
    end

    initial begin
        V_RST         = mk(4'd0,  8'b00000000, 2'b00, 2'b10, 3'b000, 2'b10, 3'b000);
        V_FETCH_RDY   = mk(4'd0,  8'b10011000, 2'b00, 2'b10, 3'b000, 2'b10, 3'b000);
        V_FETCH_STALL = mk(4'd0,  8'b10000000, 2'b00, 2'b10, 3'b000, 2'b10, 3'b000);
        V_ALUWB       = mk(4'd7,  8'b00000110, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000);
        V_FAULT       = mk(4'd13, 8'b00000001, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000);

        @(posedge clk); #1;
        cyc(0, 1, 0, V_RST, "reset_init");
        cyc(0, 1, 0, V_RST, "reset_init2");

        // add x3,x1,x2 with mem_ready high
        set_instr(7'b0110011, 3'b000, 1'b0);
        cyc(0, 0, 1, V_FETCH_RDY, "add_fetch");
        cyc(0, 0, 1, mk(4'd1, 8'b0, 2'b01, 2'b01, 3'b000, 2'b00, 3'b000), "add_decode");
        cyc(0, 0, 1, mk(4'd6, 8'b0, 2'b10, 2'b00, 3'b000, 2'b00, 3'b000), "add_execr");
        cyc(0, 0, 1, V_ALUWB, "add_aluwb");

        // sub, then reset asserted for 3 cycles mid-instruction
        set_instr(7'b0110011, 3'b000, 1'b1);
        cyc(0, 0, 1, V_FETCH_RDY, "sub_fetch");
        cyc(0, 0, 1, mk(4'd1, 8'b0, 2'b01, 2'b01, 3'b000, 2'b00, 3'b000), "sub_decode");
        cyc(0, 0, 1, mk(4'd6, 8'b0, 2'b10, 2'b00, 3'b000, 2'b00, 3'b001), "sub_execr");
        cyc(0, 1, 1, V_RST, "midreset1");
        cyc(0, 1, 1, V_RST, "midreset2");
        cyc(0, 1, 1, V_RST, "midreset3");
        cyc(0, 0, 0, V_FETCH_STALL, "post_reset_fetch");

        // sw with 3 stall cycles in MEMWRITE
        set_instr(7'b0100011, 3'b010, 1'b0);
        cyc(0, 0, 1, V_FETCH_RDY, "sw_fetch");
        cyc(0, 0, 0, mk(4'd1, 8'b0, 2'b01, 2'b01, 3'b001, 2'b00, 3'b000), "sw_decode");
        cyc(0, 0, 0, mk(4'd2, 8'b0, 2'b10, 2'b01, 3'b000, 2'b00, 3'b000), "sw_memadr");
        for (int i = 0; i < 3; i++)
            cyc(0, 0, 0, mk(4'd5, 8'b11100000, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000), "sw_memwrite_stall");
        cyc(0, 0, 1, mk(4'd5, 8'b11100010, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000), "sw_memwrite_done");

        // lw, 5 cycles
        set_instr(7'b0000011, 3'b010, 1'b0);
        cyc(0, 0, 1, V_FETCH_RDY, "lw_fetch");
        cyc(0, 0, 1, mk(4'd1, 8'b0, 2'b01, 2'b01, 3'b000, 2'b00, 3'b000), "lw_decode");
        cyc(0, 0, 1, mk(4'd2, 8'b0, 2'b10, 2'b01, 3'b000, 2'b00, 3'b000), "lw_memadr");
        cyc(0, 0, 1, mk(4'd3, 8'b10100000, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000), "lw_memread");
        cyc(0, 0, 1, mk(4'd4, 8'b00000110, 2'b00, 2'b00, 3'b000, 2'b01, 3'b000), "lw_memwb");

        // bne zero=0 -> taken; zero=1 -> not taken
        set_instr(7'b1100011, 3'b001, 1'b0);
        zero = 1'b0;
        cyc(0, 0, 1, V_FETCH_RDY, "bne_t_fetch");
        cyc(0, 0, 1, mk(4'd1, 8'b0, 2'b01, 2'b01, 3'b010, 2'b00, 3'b000), "bne_t_decode");
        cyc(0, 0, 1, mk(4'd10, 8'b00001010, 2'b10, 2'b00, 3'b000, 2'b00, 3'b001), "bne_t_branch");
        zero = 1'b1;
        cyc(0, 0, 1, V_FETCH_RDY, "bne_nt_fetch");
        cyc(0, 0, 1, mk(4'd1, 8'b0, 2'b01, 2'b01, 3'b010, 2'b00, 3'b000), "bne_nt_decode");
        cyc(0, 0, 1, mk(4'd10, 8'b00000010, 2'b10, 2'b00, 3'b000, 2'b00, 3'b001), "bne_nt_branch");

        // blt lt=1 taken; bgeu ltu=1 not taken
        zero = 1'b0; lt = 1'b1; ltu = 1'b1;
        set_instr(7'b1100011, 3'b100, 1'b0);
        cyc(0, 0, 1, V_FETCH_RDY, "blt_fetch");
        cyc(0, 0, 1, mk(4'd1, 8'b0, 2'b01, 2'b01, 3'b010, 2'b00, 3'b000), "blt_decode");
        cyc(0, 0, 1, mk(4'd10, 8'b00001010, 2'b10, 2'b00, 3'b000, 2'b00, 3'b001), "blt_branch");
        set_instr(7'b1100011, 3'b111, 1'b0);
        cyc(0, 0, 1, V_FETCH_RDY, "bgeu_fetch");
        cyc(0, 0, 1, mk(4'd1, 8'b0, 2'b01, 2'b01, 3'b010, 2'b00, 3'b000), "bgeu_decode");
        cyc(0, 0, 1, mk(4'd10, 8'b00000010, 2'b10, 2'b00, 3'b000, 2'b00, 3'b001), "bgeu_branch");
        lt = 1'b0; ltu = 1'b0;

        // jal, 4 cycles
        set_instr(7'b1101111, 3'b000, 1'b0);
        cyc(0, 0, 1, V_FETCH_RDY, "jal_fetch");
        cyc(0, 0, 1, mk(4'd1, 8'b0, 2'b01, 2'b01, 3'b011, 2'b00, 3'b000), "jal_decode");
        cyc(0, 0, 1, mk(4'd9, 8'b00001000, 2'b01, 2'b10, 3'b000, 2'b00, 3'b000), "jal_jal");
        cyc(0, 0, 1, V_ALUWB, "jal_aluwb");

        // jalr, 3 cycles
        set_instr(7'b1100111, 3'b000, 1'b0);
        cyc(0, 0, 1, V_FETCH_RDY, "jalr_fetch");
        cyc(0, 0, 1, mk(4'd1, 8'b0, 2'b01, 2'b01, 3'b000, 2'b00, 3'b000), "jalr_decode");
        cyc(0, 0, 1, mk(4'd11, 8'b00001110, 2'b10, 2'b01, 3'b000, 2'b11, 3'b000), "jalr_jalr");

        // lui
        set_instr(7'b0110111, 3'b000, 1'b0);
        cyc(0, 0, 1, V_FETCH_RDY, "lui_fetch");
        cyc(0, 0, 1, mk(4'd1, 8'b0, 2'b01, 2'b01, 3'b100, 2'b00, 3'b000), "lui_decode");
        cyc(0, 0, 1, mk(4'd12, 8'b0, 2'b11, 2'b01, 3'b100, 2'b00, 3'b000), "lui_lui");
        cyc(0, 0, 1, V_ALUWB, "lui_aluwb");

        // slti with bit30 set (must not become sub), then and/or R-type execute
        set_instr(7'b0010011, 3'b010, 1'b1);
        cyc(0, 0, 1, V_FETCH_RDY, "slti_fetch");
        cyc(0, 0, 1, mk(4'd1, 8'b0, 2'b01, 2'b01, 3'b000, 2'b00, 3'b000), "slti_decode");
        cyc(0, 0, 1, mk(4'd8, 8'b0, 2'b10, 2'b01, 3'b000, 2'b00, 3'b101), "slti_execi");
        cyc(0, 0, 1, V_ALUWB, "slti_aluwb");
        set_instr(7'b0010011, 3'b000, 1'b1);
        cyc(0, 0, 1, V_FETCH_RDY, "addi_fetch");
        cyc(0, 0, 1, mk(4'd1, 8'b0, 2'b01, 2'b01, 3'b000, 2'b00, 3'b000), "addi_decode");
        cyc(0, 0, 1, mk(4'd8, 8'b0, 2'b10, 2'b01, 3'b000, 2'b00, 3'b000), "addi_execi");
        cyc(0, 0, 1, V_ALUWB, "addi_aluwb");
        set_instr(7'b0110011, 3'b111, 1'b0);
        cyc(0, 0, 1, V_FETCH_RDY, "and_fetch");
        cyc(0, 0, 1, mk(4'd1, 8'b0, 2'b01, 2'b01, 3'b000, 2'b00, 3'b000), "and_decode");
        cyc(0, 0, 1, mk(4'd6, 8'b0, 2'b10, 2'b00, 3'b000, 2'b00, 3'b010), "and_execr");
        cyc(0, 0, 1, V_ALUWB, "and_aluwb");
        set_instr(7'b0110011, 3'b110, 1'b0);
        cyc(0, 0, 1, V_FETCH_RDY, "or_fetch");
        cyc(0, 0, 1, mk(4'd1, 8'b0, 2'b01, 2'b01, 3'b000, 2'b00, 3'b000), "or_decode");
        cyc(0, 0, 1, mk(4'd6, 8'b0, 2'b10, 2'b00, 3'b000, 2'b00, 3'b011), "or_execr");
        cyc(0, 0, 1, V_ALUWB, "or_aluwb");

        // illegal opcode -> FAULT, absorbing
        set_instr(7'b0000000, 3'b000, 1'b0);
        cyc(0, 0, 1, V_FETCH_RDY, "ill_fetch");
        cyc(0, 0, 1, mk(4'd1, 8'b0, 2'b01, 2'b01, 3'b000, 2'b00, 3'b000), "ill_decode");
        cyc(0, 0, 1, V_FAULT, "ill_fault1");
        cyc(0, 0, 1, V_FAULT, "ill_fault2");
        cyc(0, 1, 0, V_RST, "ill_reset");

        // ---- dut_b: MEM_TIMEOUT=4, reduced decoder ----
        cyc(1, 1, 0, V_RST, "b_reset");
        for (int i = 0; i < 4; i++)
            cyc(1, 0, 0, V_FETCH_STALL, "b_wd_stall");
        cyc(1, 0, 1, V_FAULT, "b_wd_fault1");
        cyc(1, 0, 1, V_FAULT, "b_wd_fault2");
        cyc(1, 0, 0, V_FAULT, "b_wd_fault3");
        cyc(1, 1, 0, V_RST, "b_wd_reset");

        // ready in the last allowed cycle beats the timeout; LUI is illegal here
        set_instr(7'b0110111, 3'b000, 1'b0);
        for (int i = 0; i < 3; i++)
            cyc(1, 0, 0, V_FETCH_STALL, "b_edge_stall");
        cyc(1, 0, 1, V_FETCH_RDY, "b_edge_ready");
        cyc(1, 0, 0, mk(4'd1, 8'b0, 2'b01, 2'b01, 3'b100, 2'b00, 3'b000), "b_lui_decode");
        cyc(1, 0, 0, V_FAULT, "b_lui_fault");
        cyc(1, 1, 0, V_RST, "b_reset2");

        // bne is illegal in the reduced decoder, beq works
        set_instr(7'b1100011, 3'b001, 1'b0);
        cyc(1, 0, 1, V_FETCH_RDY, "b_bne_fetch");
        cyc(1, 0, 1, mk(4'd1, 8'b0, 2'b01, 2'b01, 3'b010, 2'b00, 3'b000), "b_bne_decode");
        cyc(1, 0, 1, V_FAULT, "b_bne_fault");
        cyc(1, 1, 0, V_RST, "b_reset3");
        set_instr(7'b1100011, 3'b000, 1'b0);
        zero = 1'b1;
        cyc(1, 0, 1, V_FETCH_RDY, "b_beq_fetch");
        cyc(1, 0, 1, mk(4'd1, 8'b0, 2'b01, 2'b01, 3'b010, 2'b00, 3'b000), "b_beq_decode");
        cyc(1, 0, 1, mk(4'd10, 8'b00001010, 2'b10, 2'b00, 3'b000, 2'b00, 3'b001), "b_beq_branch");
        cyc(1, 0, 0, V_FETCH_STALL, "b_beq_next_fetch");

        @(negedge clk); #1;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
